// File: rtl/power_reset_pkg.sv
// -----------------------------------------------------------------------------
// power_reset_pkg
// Shared definitions for the power/reset sequencer slice:
//   - pwrState_t   : sequencer FSM state encodings (OFF..FAULT)
//   - resetCause_t : encodings reported on ResetCause
//   - DEF_*        : default tick counts for the sequencing timer
// No ports (package).
// -----------------------------------------------------------------------------
package power_reset_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_PWRUP = 3'd1,
    ST_ON    = 3'd2,
    ST_RESET = 3'd3,
    ST_PWRDN = 3'd4,
    ST_FAULT = 3'd5
  } pwrState_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_BUTTON = 2'd1,
    CAUSE_WDOG   = 2'd2,
    CAUSE_FAULT  = 2'd3
  } resetCause_t;

  localparam int DEF_PWRUP_TICKS  = 16;  // 125 ms ticks (2 s)
  localparam int DEF_PWRDN_TICKS  = 40;  // 125 ms ticks (5 s)
  localparam int DEF_RST_TICKS    = 4;   // 16 ms ticks (~64 ms)
  localparam int DEF_FAULT_HOLD_S = 3;   // 1 s ticks
  localparam int DEF_TMR_W        = 8;

endpackage

// File: rtl/power_reset_sequencer_timer.sv
// -----------------------------------------------------------------------------
// seq_tick_timer
// Loadable saturating down-counter shared by every timed phase of the
// sequencer. The owner chooses which strobe drives Tick in each state.
// Ports:
//   SlowClock  in          32,768 Hz clock
//   MainReset  in          asynchronous reset, active-high (count -> 0)
//   Load       in          load LoadValue this cycle (wins over Tick)
//   LoadValue  in  TMR_W   value to load
//   Tick       in          decrement strobe (ignored once count is 0)
//   Zero       out         count == 0
// -----------------------------------------------------------------------------
module seq_tick_timer #(
  parameter int TMR_W = 8
) (
  input  logic             SlowClock,
  input  logic             MainReset,
  input  logic             Load,
  input  logic [TMR_W-1:0] LoadValue,
  input  logic             Tick,
  output logic             Zero
);

  logic [TMR_W-1:0] countR;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge SlowClock or posedge MainReset) begin
    if (MainReset) begin
      countR <= {TMR_W{1'b0}};
    end else if (Load) begin
      countR <= LoadValue;
    end else if (Tick && (countR != {TMR_W{1'b0}})) begin
      countR <= countR - {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      countR <= countR;
    end
  end

  assign Zero = (countR == {TMR_W{1'b0}});

endmodule

// File: rtl/power_reset_sequencer.sv
// -----------------------------------------------------------------------------
// power_reset_sequencer
// Arbitrates power-button, reset-button and watchdog requests onto the board
// power-supply enable and the chipset reset line, timing each phase off the
// shared 16 ms / 125 ms / 1 s strobes. All outputs are registered.
// Build option: define WDT_RESET_EN to act on WatchDogReset rising edges;
// without it the port is present but ignored.
// Ports:
//   SlowClock       in     32,768 Hz clock
//   MainReset       in     asynchronous reset, active-high
//   Strobe16ms      in     1-cycle pulse every 16 ms
//   Strobe125ms     in     1-cycle pulse every 125 ms
//   Strobe1s        in     1-cycle pulse every 1 s
//   PowerInterrupt  in     1-cycle power-button event
//   ResetInterrupt  in     1-cycle reset-button event
//   WatchDogReset   in     watchdog reset request (level)
//   PowerGood       in     supply power-good (synchronised)
//   PsOn            out    power-supply enable
//   SysResetOut     out    chipset reset, active-high
//   State           out 3  current FSM state
//   ResetCause      out 2  0 none, 1 button, 2 watchdog, 3 power fault
//   PendingOff      out    power-off queued while in RESET
// -----------------------------------------------------------------------------
module power_reset_sequencer
  import power_reset_pkg::*;
#(
  parameter int PWRUP_TICKS  = DEF_PWRUP_TICKS,
  parameter int PWRDN_TICKS  = DEF_PWRDN_TICKS,
  parameter int RST_TICKS    = DEF_RST_TICKS,
  parameter int FAULT_HOLD_S = DEF_FAULT_HOLD_S,
  parameter int TMR_W        = DEF_TMR_W
) (
  input  logic       SlowClock,
  input  logic       MainReset,
  input  logic       Strobe16ms,
  input  logic       Strobe125ms,
  input  logic       Strobe1s,
  input  logic       PowerInterrupt,
  input  logic       ResetInterrupt,
  input  logic       WatchDogReset,
  input  logic       PowerGood,
  output logic       PsOn,
  output logic       SysResetOut,
  output logic [2:0] State,
  output logic [1:0] ResetCause,
  output logic       PendingOff
);

  localparam logic [TMR_W-1:0] PWRUP_LOAD = TMR_W'(PWRUP_TICKS);
  localparam logic [TMR_W-1:0] PWRDN_LOAD = TMR_W'(PWRDN_TICKS);
  localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_TICKS);
  localparam logic [TMR_W-1:0] FAULT_LOAD = TMR_W'(FAULT_HOLD_S);

  pwrState_t        stateR;
  pwrState_t        nextStateS;
  resetCause_t      causeR;
  resetCause_t      nextCauseS;
  logic             pendingR;
  logic             nextPendingS;
  logic             psOnR;
  logic             sysRstR;
  logic             loadS;
  logic [TMR_W-1:0] loadValS;
  logic             tickS;
  logic             timerZeroS;
  logic             wdEdgeS;

`ifdef WDT_RESET_EN
  logic wdPrevR;

  // One-stage history of the watchdog level for rising-edge detection.
  always_ff @(posedge SlowClock or posedge MainReset) begin
    if (MainReset) begin
      wdPrevR <= 1'b0;
    end else begin
      wdPrevR <= WatchDogReset;
    end
  end

  assign wdEdgeS = WatchDogReset & ~wdPrevR;
`else
  logic unusedWatchDogS;
  assign unusedWatchDogS = WatchDogReset;
  assign wdEdgeS         = 1'b0;
`endif

  seq_tick_timer #(.TMR_W(TMR_W)) uTimer (
    .SlowClock (SlowClock),
    .MainReset (MainReset),
    .Load      (loadS),
    .LoadValue (loadValS),
    .Tick      (tickS),
    .Zero      (timerZeroS)
  );

  // Next-state, timer control and next output values.
  always_comb begin
    nextStateS   = stateR;
    nextCauseS   = causeR;
    nextPendingS = pendingR;
    loadS        = 1'b0;
    loadValS     = {TMR_W{1'b0}};
    tickS        = 1'b0;
    case (stateR)
      ST_OFF: begin
        nextPendingS = 1'b0;
        if (PowerInterrupt) begin
          nextStateS = ST_PWRUP;
          loadS      = 1'b1;
          loadValS   = PWRUP_LOAD;
        end else begin
          nextStateS = ST_OFF;
        end
      end
      ST_PWRUP: begin
        tickS = Strobe125ms;
        // PowerGood is checked first so it wins over a coincident expiry.
        if (PowerGood) begin
          nextStateS = ST_ON;
        end else if (timerZeroS) begin
          nextStateS = ST_FAULT;
          nextCauseS = CAUSE_FAULT;
          loadS      = 1'b1;
          loadValS   = FAULT_LOAD;
        end else begin
          nextStateS = ST_PWRUP;
        end
      end
      ST_ON: begin
        if (!PowerGood) begin
          nextStateS = ST_FAULT;
          nextCauseS = CAUSE_FAULT;
          loadS      = 1'b1;
          loadValS   = FAULT_LOAD;
        end else if (PowerInterrupt) begin
          nextStateS = ST_PWRDN;
          nextCauseS = CAUSE_BUTTON;
          loadS      = 1'b1;
          loadValS   = PWRDN_LOAD;
        end else if (wdEdgeS) begin
          nextStateS = ST_RESET;
          nextCauseS = CAUSE_WDOG;
          loadS      = 1'b1;
          loadValS   = RST_LOAD;
        end else if (ResetInterrupt) begin
          nextStateS = ST_RESET;
          nextCauseS = CAUSE_BUTTON;
          loadS      = 1'b1;
          loadValS   = RST_LOAD;
        end else begin
          nextStateS = ST_ON;
        end
      end
      ST_RESET: begin
        tickS = Strobe16ms;
        if (!PowerGood) begin
          nextStateS   = ST_FAULT;
          nextPendingS = 1'b0;
          loadS        = 1'b1;
          loadValS     = FAULT_LOAD;
        end else if (timerZeroS) begin
          // A power request landing on the final cycle is still honoured.
          if (pendingR || PowerInterrupt) begin
            nextStateS   = ST_PWRDN;
            nextPendingS = 1'b0;
            loadS        = 1'b1;
            loadValS     = PWRDN_LOAD;
          end else begin
            nextStateS = ST_ON;
          end
        end else if (PowerInterrupt) begin
          nextStateS   = ST_RESET;
          nextPendingS = 1'b1;
        end else begin
          nextStateS = ST_RESET;
        end
      end
      ST_PWRDN: begin
        tickS = Strobe125ms;
        if (!PowerGood) begin
          nextStateS = ST_OFF;
        end else if (timerZeroS) begin
          nextStateS = ST_FAULT;
          nextCauseS = CAUSE_FAULT;
          loadS      = 1'b1;
          loadValS   = FAULT_LOAD;
        end else begin
          nextStateS = ST_PWRDN;
        end
      end
      ST_FAULT: begin
        tickS = Strobe1s;
        if (timerZeroS) begin
          nextStateS = ST_OFF;
        end else begin
          nextStateS = ST_FAULT;
        end
      end
      default: begin
        // Encodings 6/7 fall back to OFF on the next edge.
        nextStateS   = ST_OFF;
        nextPendingS = 1'b0;
      end
    endcase
  end

  // State, cause and registered pin drivers (derived from the next state).
  always_ff @(posedge SlowClock or posedge MainReset) begin
    if (MainReset) begin
      stateR   <= ST_OFF;
      causeR   <= CAUSE_NONE;
      pendingR <= 1'b0;
      psOnR    <= 1'b0;
      sysRstR  <= 1'b0;
    end else begin
      stateR   <= nextStateS;
      causeR   <= nextCauseS;
      pendingR <= nextPendingS;
      psOnR    <= (nextStateS == ST_PWRUP) || (nextStateS == ST_ON) ||
                  (nextStateS == ST_RESET);
      sysRstR  <= (nextStateS == ST_RESET);
    end
  end

  assign PsOn        = psOnR;
  assign SysResetOut = sysRstR;
  assign State       = stateR;
  assign ResetCause  = causeR;
  assign PendingOff  = pendingR;

endmodule

// File: tb/tb_power_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_power_reset_sequencer
// Directed scenario bench for power_reset_sequencer. Inputs change and outputs
// are sampled on the falling edge of SlowClock.
// -----------------------------------------------------------------------------
module tb_power_reset_sequencer;

  logic       SlowClock = 1'b0;
  logic       MainReset;
  logic       Strobe16ms, Strobe125ms, Strobe1s;
  logic       PowerInterrupt, ResetInterrupt, WatchDogReset, PowerGood;
  logic       PsOn, SysResetOut, PendingOff;
  logic [2:0] State;
  logic [1:0] ResetCause;

  int testsRun = 0;
  int testsFailed = 0;

  power_reset_sequencer dut (
    .SlowClock      (SlowClock),
    .MainReset      (MainReset),
    .Strobe16ms     (Strobe16ms),
    .Strobe125ms    (Strobe125ms),
    .Strobe1s       (Strobe1s),
    .PowerInterrupt (PowerInterrupt),
    .ResetInterrupt (ResetInterrupt),
    .WatchDogReset  (WatchDogReset),
    .PowerGood      (PowerGood),
    .PsOn           (PsOn),
    .SysResetOut    (SysResetOut),
    .State          (State),
    .ResetCause     (ResetCause),
    .PendingOff     (PendingOff)
  );

  always #5 SlowClock = ~SlowClock;

  task automatic cyc();
    @(negedge SlowClock);
  endtask

  task automatic s125();
    Strobe125ms = 1'b1; cyc(); Strobe125ms = 1'b0; cyc();
  endtask

  task automatic s16();
    Strobe16ms = 1'b1; cyc(); Strobe16ms = 1'b0; cyc();
  endtask

  task automatic s1();
    Strobe1s = 1'b1; cyc(); Strobe1s = 1'b0; cyc();
  endtask

  // Brings the DUT from OFF to ON with PowerGood already high.
  task automatic goOn();
    PowerGood = 1'b1;
    PowerInterrupt = 1'b1; cyc(); PowerInterrupt = 1'b0; cyc();
  endtask

  task automatic test_reset();
    MainReset = 1'b1;
    repeat (2) cyc();
    testsRun++;
    if ({State, PsOn, SysResetOut, ResetCause, PendingOff} !== 8'b000_0_0_00_0) begin
      testsFailed++;
      $display("FAIL reset_state: got st=%0d pson=%0b rst=%0b cause=%0d pend=%0b, want all 0",
               State, PsOn, SysResetOut, ResetCause, PendingOff);
    end
    MainReset = 1'b0;
    cyc();
  endtask

  task automatic test_powerup();
    PowerInterrupt = 1'b1; cyc(); PowerInterrupt = 1'b0;
    testsRun++;
    if (PsOn !== 1'b1 || State !== 3'd1) begin
      testsFailed++;
      $display("FAIL pwrup_entry: got pson=%0b st=%0d, want 1/1", PsOn, State);
    end
    repeat (5) s125();
    testsRun++;
    if (State !== 3'd1) begin
      testsFailed++;
      $display("FAIL pwrup_wait: got st=%0d, want 1", State);
    end
    PowerGood = 1'b1; cyc();
    testsRun++;
    if (State !== 3'd2 || PsOn !== 1'b1 || ResetCause !== 2'd0) begin
      testsFailed++;
      $display("FAIL pwrup_on: got st=%0d pson=%0b cause=%0d, want 2/1/0", State, PsOn, ResetCause);
    end
    // Power back off through PWRDN.
    PowerInterrupt = 1'b1; cyc(); PowerInterrupt = 1'b0;
    testsRun++;
    if (State !== 3'd4 || PsOn !== 1'b0 || ResetCause !== 2'd1) begin
      testsFailed++;
      $display("FAIL pwrdn_entry: got st=%0d pson=%0b cause=%0d, want 4/0/1", State, PsOn, ResetCause);
    end
    PowerGood = 1'b0; cyc();
    testsRun++;
    if (State !== 3'd0) begin
      testsFailed++;
      $display("FAIL pwrdn_off: got st=%0d, want 0", State);
    end
  endtask

  task automatic test_pwrup_timeout();
    PowerGood = 1'b0;
    PowerInterrupt = 1'b1; cyc(); PowerInterrupt = 1'b0;
    repeat (15) s125();
    testsRun++;
    if (State !== 3'd1) begin
      testsFailed++;
      $display("FAIL timeout_early: got st=%0d after 15 ticks, want 1", State);
    end
    s125();
    testsRun++;
    if (State !== 3'd5 || PsOn !== 1'b0 || ResetCause !== 2'd3) begin
      testsFailed++;
      $display("FAIL timeout_fault: got st=%0d pson=%0b cause=%0d, want 5/0/3", State, PsOn, ResetCause);
    end
    // Button presses are ignored in FAULT.
    PowerInterrupt = 1'b1; cyc(); PowerInterrupt = 1'b0;
    repeat (2) s1();
    testsRun++;
    if (State !== 3'd5) begin
      testsFailed++;
      $display("FAIL fault_hold: got st=%0d after 2 s, want 5", State);
    end
    s1();
    testsRun++;
    if (State !== 3'd0 || ResetCause !== 2'd3) begin
      testsFailed++;
      $display("FAIL fault_exit: got st=%0d cause=%0d, want 0/3", State, ResetCause);
    end
  endtask

  task automatic test_reset_button();
    int n;
    goOn();
    ResetInterrupt = 1'b1; cyc(); ResetInterrupt = 1'b0;
    testsRun++;
    if (SysResetOut !== 1'b1 || State !== 3'd3 || PsOn !== 1'b1) begin
      testsFailed++;
      $display("FAIL rst_entry: got rst=%0b st=%0d pson=%0b, want 1/3/1", SysResetOut, State, PsOn);
    end
    n = 0;
    while (SysResetOut === 1'b1 && n < 20) begin
      Strobe16ms = 1'b1;
      if (n == 1) ResetInterrupt = 1'b1;   // retrigger attempt mid-pulse
      cyc();
      Strobe16ms = 1'b0; ResetInterrupt = 1'b0;
      cyc();
      n++;
    end
    testsRun++;
    if (n !== 4) begin
      testsFailed++;
      $display("FAIL rst_width: got %0d 16ms ticks, want 4", n);
    end
    testsRun++;
    if (State !== 3'd2 || ResetCause !== 2'd1 || PsOn !== 1'b1) begin
      testsFailed++;
      $display("FAIL rst_exit: got st=%0d cause=%0d pson=%0b, want 2/1/1", State, ResetCause, PsOn);
    end
  endtask

  task automatic test_wdt_vs_button();
    logic [1:0] expCause;
`ifdef WDT_RESET_EN
    expCause = 2'd2;
`else
    expCause = 2'd1;
`endif
    WatchDogReset = 1'b1; ResetInterrupt = 1'b1; cyc(); ResetInterrupt = 1'b0;
    testsRun++;
    if (State !== 3'd3 || ResetCause !== expCause) begin
      testsFailed++;
      $display("FAIL wdt_coincide: got st=%0d cause=%0d, want 3/%0d", State, ResetCause, expCause);
    end
    repeat (4) s16();
    WatchDogReset = 1'b0;
    cyc();
    testsRun++;
    if (State !== 3'd2 || SysResetOut !== 1'b0) begin
      testsFailed++;
      $display("FAIL wdt_exit: got st=%0d rst=%0b, want 2/0", State, SysResetOut);
    end
  endtask

  task automatic test_pending_off();
    ResetInterrupt = 1'b1; cyc(); ResetInterrupt = 1'b0;
    s16();
    PowerInterrupt = 1'b1; cyc(); PowerInterrupt = 1'b0;
    testsRun++;
    if (PendingOff !== 1'b1 || SysResetOut !== 1'b1 || State !== 3'd3) begin
      testsFailed++;
      $display("FAIL pend_set: got pend=%0b rst=%0b st=%0d, want 1/1/3", PendingOff, SysResetOut, State);
    end
    repeat (3) s16();
    testsRun++;
    if (SysResetOut !== 1'b0 || State !== 3'd4 || PsOn !== 1'b0 || PendingOff !== 1'b0) begin
      testsFailed++;
      $display("FAIL pend_pwrdn: got rst=%0b st=%0d pson=%0b pend=%0b, want 0/4/0/0",
               SysResetOut, State, PsOn, PendingOff);
    end
    PowerGood = 1'b0; cyc();
    testsRun++;
    if (State !== 3'd0) begin
      testsFailed++;
      $display("FAIL pend_off: got st=%0d, want 0", State);
    end
  endtask

  task automatic test_fault_priority();
    goOn();
    // Supply loss outranks a coincident power-button event.
    PowerGood = 1'b0; PowerInterrupt = 1'b1; cyc(); PowerInterrupt = 1'b0;
    testsRun++;
    if (State !== 3'd5 || PsOn !== 1'b0 || ResetCause !== 2'd3) begin
      testsFailed++;
      $display("FAIL on_fault: got st=%0d pson=%0b cause=%0d, want 5/0/3", State, PsOn, ResetCause);
    end
    repeat (3) s1();
    testsRun++;
    if (State !== 3'd0) begin
      testsFailed++;
      $display("FAIL on_fault_exit: got st=%0d, want 0", State);
    end
  endtask

  task automatic test_async_reset();
    goOn();
    ResetInterrupt = 1'b1; cyc(); ResetInterrupt = 1'b0;
    testsRun++;
    if (SysResetOut !== 1'b1) begin
      testsFailed++;
      $display("FAIL async_pre: got rst=%0b, want 1", SysResetOut);
    end
    #2 MainReset = 1'b1;
    #1;
    testsRun++;
    if ({State, PsOn, SysResetOut, ResetCause, PendingOff} !== 8'b000_0_0_00_0) begin
      testsFailed++;
      $display("FAIL async_reset: got st=%0d pson=%0b rst=%0b cause=%0d pend=%0b, want all 0",
               State, PsOn, SysResetOut, ResetCause, PendingOff);
    end
    cyc();
    MainReset = 1'b0;
    cyc();
  endtask

  initial begin
    MainReset = 1'b1;
    Strobe16ms = 1'b0; Strobe125ms = 1'b0; Strobe1s = 1'b0;
    PowerInterrupt = 1'b0; ResetInterrupt = 1'b0;
    WatchDogReset = 1'b0; PowerGood = 1'b0;
    test_reset();
    test_powerup();
    test_pwrup_timeout();
    test_reset_button();
    test_wdt_vs_button();
    test_pending_off();
    test_fault_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
